// File: rtl/reg_writeback_pkg.sv
// Shared core definitions: load-type encodings, default widths and the
// retire-source selector used by the writeback stage.
package reg_writeback_pkg;

   localparam int DEF_BANK_WIDTH     = 5;
   localparam int DEF_REGISTER_WIDTH = 32;
   localparam int LQ_MAX             = 4;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      SRC_NONE   = 2'd0,
      SRC_ALU    = 2'd1,
      SRC_QUEUE  = 2'd2,
      SRC_BYPASS = 2'd3
   } src_t;

endpackage

// File: rtl/reg_writeback_load_extend.sv
// Combinational load extension: picks the byte/halfword addressed by the low
// address bits out of an aligned word and sign- or zero-extends it.
// The byte/halfword lanes assume a 32-bit (or wider) memory word.
module load_extend
   import reg_writeback_pkg::*;
#(
   parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH
) (
   input  logic [REGISTER_WIDTH-1:0] raw,
   input  logic [2:0]                funct3,
   input  logic [1:0]                addr_lo,
   output logic [REGISTER_WIDTH-1:0] ext
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane select then extension; unknown encodings behave as a full-word load.
   always_comb begin
      byte_lane = raw[{addr_lo, 3'b000} +: 8];
      half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];
      case (funct3)
         F3_LB:   ext = {{(REGISTER_WIDTH-8){byte_lane[7]}}, byte_lane};
         F3_LH:   ext = {{(REGISTER_WIDTH-16){half_lane[15]}}, half_lane};
         F3_LBU:  ext = {{(REGISTER_WIDTH-8){1'b0}}, byte_lane};
         F3_LHU:  ext = {{(REGISTER_WIDTH-16){1'b0}}, half_lane};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/reg_writeback.sv
// Register writeback stage. Arbitrates one retire per cycle between the ALU,
// a small load-result FIFO and a direct LSU bypass, and registers the chosen
// write toward the register bank.
// Handshake: a load is transferred on any rising edge where lsu_valid and
// lsu_ready are both high; lsu_ready depends only on the registered queue
// count, so it never combinationally depends on lsu_valid or on a pop.
// The ALU has no backpressure and always wins arbitration.
module reg_writeback
   import reg_writeback_pkg::*;
#(
   parameter int BANK_WIDTH     = DEF_BANK_WIDTH,
   parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH,
   parameter int LQ_DEPTH       = 2   // 1..4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid,
   input  logic [BANK_WIDTH-1:0]     alu_rd,
   input  logic [REGISTER_WIDTH-1:0] alu_data,
   input  logic                      lsu_valid,
   output logic                      lsu_ready,
   input  logic [BANK_WIDTH-1:0]     lsu_rd,
   input  logic [REGISTER_WIDTH-1:0] lsu_data,
   input  logic [2:0]                lsu_funct3,
   input  logic [1:0]                lsu_addr_lo,
   output logic                      reg_w,
   output logic [BANK_WIDTH-1:0]     rd_sel,
   output logic [REGISTER_WIDTH-1:0] rd_data,
   input  logic [BANK_WIDTH-1:0]     query_sel,
   output logic                      query_hit
);

   // Storage is sized for the largest legal depth; only LQ_DEPTH slots are used.
   logic [BANK_WIDTH-1:0]     q_rd   [LQ_MAX];
   logic [REGISTER_WIDTH-1:0] q_data [LQ_MAX];
   logic [LQ_MAX-1:0]         q_valid;
   logic [1:0]                head;
   logic [1:0]                tail;
   logic [2:0]                count;

   logic [REGISTER_WIDTH-1:0] lsu_ext;
   logic                      accept;
   logic                      push;
   logic                      pop;
   src_t                      src;
   logic [BANK_WIDTH-1:0]     sel_rd;
   logic [REGISTER_WIDTH-1:0] sel_data;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'(LQ_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   load_extend #(.REGISTER_WIDTH(REGISTER_WIDTH)) u_load_extend (
      .raw     (lsu_data),
      .funct3  (lsu_funct3),
      .addr_lo (lsu_addr_lo),
      .ext     (lsu_ext)
   );

   assign lsu_ready = (count < 3'(LQ_DEPTH));
   assign accept    = lsu_valid && lsu_ready;

   // Retire arbitration: ALU, then queue head, then bypass of a fresh load.
   always_comb begin
      src      = SRC_NONE;
      sel_rd   = alu_rd;
      sel_data = alu_data;
      pop      = 1'b0;
      push     = 1'b0;
      if (alu_valid) begin
         src  = SRC_ALU;
         push = accept;
      end else if (count != 3'd0) begin
         src      = SRC_QUEUE;
         sel_rd   = q_rd[head];
         sel_data = q_data[head];
         pop      = 1'b1;
         push     = accept;
      end else if (accept) begin
         src      = SRC_BYPASS;
         sel_rd   = lsu_rd;
         sel_data = lsu_ext;
      end
   end

   // Hazard query: any occupied slot whose destination matches (x0 never hits).
   always_comb begin
      query_hit = 1'b0;
      for (int i = 0; i < LQ_MAX; i++) begin
         if (q_valid[i] && (q_rd[i] == query_sel)) query_hit = 1'b1;
      end
      if (query_sel == '0) query_hit = 1'b0;
   end

   // Queue bookkeeping; reset discards every entry at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head    <= 2'd0;
         tail    <= 2'd0;
         count   <= 3'd0;
         q_valid <= '0;
      end else begin
         if (pop) begin
            head          <= next_ptr(head);
            q_valid[head] <= 1'b0;
         end
         if (push) begin
            tail          <= next_ptr(tail);
            q_valid[tail] <= 1'b1;
         end
         if (push && !pop)      count <= count + 3'd1;
         else if (pop && !push) count <= count - 3'd1;
      end
   end

   // Queue payload; occupancy is tracked by q_valid so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[tail]   <= lsu_rd;
         q_data[tail] <= lsu_ext;
      end
   end

   // Registered bank write; x0 retires are consumed without a write strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_w   <= 1'b0;
         rd_sel  <= '0;
         rd_data <= '0;
      end else begin
         reg_w <= (src != SRC_NONE) && (sel_rd != '0);
         if (src != SRC_NONE) begin
            rd_sel  <= sel_rd;
            rd_data <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: hand-computed vectors with immediate
// assertions, covering ALU retire, bypass extension, collisions, a full
// queue, x0 handling and mid-operation reset.
module tb_reg_writeback;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic [2:0]  lsu_funct3;
   logic [1:0]  lsu_addr_lo;
   logic        reg_w;
   logic [4:0]  rd_sel;
   logic [31:0] rd_data;
   logic [4:0]  query_sel;
   logic        query_hit;

   int vectors;
   int miscompares;

   logic [2:0]  f3_tab  [8];
   logic [1:0]  lo_tab  [8];
   logic [31:0] exp_tab [8];

   reg_writeback #(.BANK_WIDTH(5), .REGISTER_WIDTH(32), .LQ_DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .lsu_funct3  (lsu_funct3),
      .lsu_addr_lo (lsu_addr_lo),
      .reg_w       (reg_w),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .query_sel   (query_sel),
      .query_hit   (query_hit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge so registered outputs are settled.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v;
      alu_rd    = rd;
      alu_data  = d;
   endtask

   task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d,
                          input logic [2:0] f3, input logic [1:0] lo);
      lsu_valid   = v;
      lsu_rd      = rd;
      lsu_data    = d;
      lsu_funct3  = f3;
      lsu_addr_lo = lo;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      query_sel   = 5'd0;
      set_alu(1'b0, 5'd0, 32'h0);
      set_lsu(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);

      // raw word 0x8765F0A1 through each load type
      f3_tab[0] = 3'b000; lo_tab[0] = 2'd0; exp_tab[0] = 32'hFFFFFFA1;
      f3_tab[1] = 3'b000; lo_tab[1] = 2'd3; exp_tab[1] = 32'hFFFFFF87;
      f3_tab[2] = 3'b001; lo_tab[2] = 2'd2; exp_tab[2] = 32'hFFFF8765;
      f3_tab[3] = 3'b001; lo_tab[3] = 2'd0; exp_tab[3] = 32'hFFFFF0A1;
      f3_tab[4] = 3'b010; lo_tab[4] = 2'd1; exp_tab[4] = 32'h8765F0A1;
      f3_tab[5] = 3'b100; lo_tab[5] = 2'd2; exp_tab[5] = 32'h00000065;
      f3_tab[6] = 3'b101; lo_tab[6] = 2'd0; exp_tab[6] = 32'h0000F0A1;
      f3_tab[7] = 3'b011; lo_tab[7] = 2'd3; exp_tab[7] = 32'h8765F0A1;

      // reset state
      #12;
      chk("rst_reg_w", 32'(reg_w), 32'd0);
      chk("rst_rd_sel", 32'(rd_sel), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
      rst = 1'b1;
      tick();
      chk("idle_after_rst_reg_w", 32'(reg_w), 32'd0);

      // ALU only
      set_alu(1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      chk("alu_reg_w", 32'(reg_w), 32'd1);
      chk("alu_rd_sel", 32'(rd_sel), 32'd5);
      chk("alu_rd_data", rd_data, 32'hDEADBEEF);
      tick();
      chk("idle_reg_w", 32'(reg_w), 32'd0);
      chk("idle_hold_sel", 32'(rd_sel), 32'd5);
      chk("idle_hold_data", rd_data, 32'hDEADBEEF);

      // bypass LB
      set_lsu(1'b1, 5'd3, 32'h00008000, 3'b000, 2'd1);
      #1 chk("byp_ready", 32'(lsu_ready), 32'd1);
      tick();
      lsu_valid = 1'b0;
      chk("byp_reg_w", 32'(reg_w), 32'd1);
      chk("byp_rd_sel", 32'(rd_sel), 32'd3);
      chk("byp_rd_data", rd_data, 32'hFFFFFF80);

      // extension table through bypass
      for (int i = 0; i < 8; i++) begin
         set_lsu(1'b1, 5'(9 + i), 32'h8765F0A1, f3_tab[i], lo_tab[i]);
         tick();
         lsu_valid = 1'b0;
         chk($sformatf("ext%0d_sel", i), 32'(rd_sel), 32'(9 + i));
         chk($sformatf("ext%0d_data", i), rd_data, exp_tab[i]);
      end
      tick();

      // collision: ALU x1 and LHU x2 in the same cycle
      set_alu(1'b1, 5'd1, 32'h11111111);
      set_lsu(1'b1, 5'd2, 32'hABCD1234, 3'b101, 2'd2);
      query_sel = 5'd2;
      #1 chk("col_hit_before", 32'(query_hit), 32'd0);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      lsu_valid = 1'b0;
      #1;
      chk("col_c1_sel", 32'(rd_sel), 32'd1);
      chk("col_c1_data", rd_data, 32'h11111111);
      chk("col_c1_hit", 32'(query_hit), 32'd1);
      tick();
      chk("col_c2_reg_w", 32'(reg_w), 32'd1);
      chk("col_c2_sel", 32'(rd_sel), 32'd2);
      chk("col_c2_data", rd_data, 32'h0000ABCD);
      #1 chk("col_c2_hit", 32'(query_hit), 32'd0);
      tick();
      chk("col_c3_reg_w", 32'(reg_w), 32'd0);

      // full queue: ALU busy 4 cycles, loads x6, x7, x8
      set_alu(1'b1, 5'd20, 32'h20);
      set_lsu(1'b1, 5'd6, 32'h606, 3'b010, 2'd0);
      #1 chk("full_rdy0", 32'(lsu_ready), 32'd1);
      tick();
      chk("full_alu_sel", 32'(rd_sel), 32'd20);
      set_lsu(1'b1, 5'd7, 32'h707, 3'b010, 2'd0);
      #1 chk("full_rdy1", 32'(lsu_ready), 32'd1);
      tick();
      set_lsu(1'b1, 5'd8, 32'h808, 3'b010, 2'd0);
      query_sel = 5'd7;
      #1;
      chk("full_rdy2", 32'(lsu_ready), 32'd0);
      chk("full_hit7", 32'(query_hit), 32'd1);
      tick();
      #1 chk("full_rdy3", 32'(lsu_ready), 32'd0);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      #1 chk("full_pop_no_ready", 32'(lsu_ready), 32'd0);
      tick();
      chk("full_x6_w", 32'(reg_w), 32'd1);
      chk("full_x6_sel", 32'(rd_sel), 32'd6);
      chk("full_x6_data", rd_data, 32'h606);
      #1 chk("full_rdy5", 32'(lsu_ready), 32'd1);
      tick();
      lsu_valid = 1'b0;
      chk("full_x7_sel", 32'(rd_sel), 32'd7);
      chk("full_x7_data", rd_data, 32'h707);
      tick();
      chk("full_x8_sel", 32'(rd_sel), 32'd8);
      chk("full_x8_data", rd_data, 32'h808);
      tick();
      chk("full_drain_reg_w", 32'(reg_w), 32'd0);

      // x0 handling
      set_alu(1'b1, 5'd0, 32'h1);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      chk("x0_alu_reg_w", 32'(reg_w), 32'd0);
      set_alu(1'b1, 5'd21, 32'h21);
      set_lsu(1'b1, 5'd0, 32'h5, 3'b010, 2'd0);
      query_sel = 5'd0;
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      lsu_valid = 1'b0;
      chk("x0_alu21_w", 32'(reg_w), 32'd1);
      #1 chk("x0_hit", 32'(query_hit), 32'd0);
      tick();
      chk("x0_pop_reg_w", 32'(reg_w), 32'd0);
      tick();

      // reset mid-operation with two queued entries
      set_alu(1'b1, 5'd22, 32'h22);
      set_lsu(1'b1, 5'd12, 32'hAA, 3'b010, 2'd0);
      tick();
      set_lsu(1'b1, 5'd13, 32'hBB, 3'b010, 2'd0);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      lsu_valid = 1'b0;
      chk("pre_rst_reg_w", 32'(reg_w), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_reg_w", 32'(reg_w), 32'd0);
      chk("mid_rst_rd_sel", 32'(rd_sel), 32'd0);
      chk("mid_rst_rd_data", rd_data, 32'd0);
      chk("mid_rst_ready", 32'(lsu_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("post_rst%0d_reg_w", i), 32'(reg_w), 32'd0);
      end
      query_sel = 5'd12;
      #1;
      chk("post_rst_hit", 32'(query_hit), 32'd0);
      chk("post_rst_ready", 32'(lsu_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter BANK_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter REGISTER_WIDTH, default 32, data width.
REQ-003 SHALL have parameter LQ_DEPTH, default 2, load-result queue entries; allowed range 1..4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 alu_valid  in  1  ALU result present this cycle; no backpressure path.
REQ-007 alu_rd  in  BANK_WIDTH  ALU destination register.
REQ-008 alu_data  in  REGISTER_WIDTH  ALU result.
REQ-009 lsu_valid  in  1  load result offered.
REQ-010 lsu_ready  out  1  load result accepted when lsu_valid && lsu_ready.
REQ-011 lsu_rd  in  BANK_WIDTH  load destination register.
REQ-012 lsu_data  in  REGISTER_WIDTH  raw aligned memory word.
REQ-013 lsu_funct3  in  3  load type (LB/LH/LW/LBU/LHU encoding).
REQ-014 lsu_addr_lo  in  2  byte offset of load address.
REQ-015 reg_w  out  1  register-bank write enable, registered.
REQ-016 rd_sel  out  BANK_WIDTH  register-bank write index, registered.
REQ-017 rd_data  out  REGISTER_WIDTH  register-bank write data, registered.
REQ-018 query_sel  in  BANK_WIDTH  hazard query index from decode.
REQ-019 query_hit  out  1  combinational: 1 when any queued entry targets query_sel and query_sel != 0.

Function
REQ-020 Each cycle SHALL select exactly one retire source, priority: ALU (alu_valid) > queue head (queue non-empty) > bypass (LSU handshake with queue empty); otherwise no retire.
REQ-021 Selected source SHALL appear on reg_w/rd_sel/rd_data at the next rising edge (latency 1); with no source, reg_w SHALL be 0 next cycle and rd_sel/rd_data hold.
REQ-022 Retire with destination index 0 SHALL be consumed normally but drive reg_w = 0.
REQ-023 lsu_ready SHALL equal (queue count < LQ_DEPTH), derived from registered count only; a same-cycle pop SHALL NOT raise lsu_ready.
REQ-024 Accepted LSU result not taken by bypass SHALL be enqueued at tail; simultaneous push and pop SHALL leave count unchanged, order preserved (FIFO).
REQ-025 Load extension at acceptance: 000 LB sign-extend byte at lsu_addr_lo; 001 LH sign-extend halfword at lsu_addr_lo[1]; 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend halfword; other codes SHALL be treated as LW.
REQ-026 Queue SHALL store the extended value, not the raw word.
REQ-027 Queue pointers SHALL wrap modulo LQ_DEPTH; count SHALL never exceed LQ_DEPTH or underflow.
REQ-028 ALU retiring while queue is full and LSU offers: LSU SHALL stall (lsu_ready = 0), no entry lost or duplicated.

Reset
REQ-029 While rst = 0: reg_w = 0, rd_sel = 0, rd_data = 0, queue count = 0, pointers = 0, lsu_ready = 1 after release.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries immediately; no write SHALL issue from pre-reset entries after release.

Structure
REQ-031 Load funct3 encodings and the BANK_WIDTH/REGISTER_WIDTH defaults SHALL live in the shared core package.
REQ-032 Load extension SHALL be a separate combinational sub-module load_extend; queue and arbitration stay in reg_writeback.

Verification
REQ-033 ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle reg_w=1, rd_sel=5, rd_data=0xDEADBEEF.
REQ-034 Bypass LB: queue empty, lsu_data=0x00008000, funct3=000, addr_lo=1, rd=3 -> next cycle rd_data=0xFFFFFF80, rd_sel=3.
REQ-035 Collision: ALU (rd=1) and LSU LHU (rd=2, data=0xABCD1234, addr_lo=2) same cycle, then idle -> cycle+1 write x1, cycle+2 write x2 with 0x0000ABCD; query_hit=1 for query_sel=2 during cycle+1 only.
REQ-036 Full queue: alu_valid held 4 cycles, LSU offering rd=6,7,8 with LQ_DEPTH=2 -> lsu_ready=0 after two accepts; after ALU stops, x6 then x7 then x8 written in order.
REQ-037 x0: ALU rd=0 data=0x1 -> reg_w=0 next cycle; query_sel=0 -> query_hit=0 always.
REQ-038 Reset mid-operation: two entries queued, rst pulsed low between edges -> reg_w=0 immediately, no write of those entries afterwards, lsu_ready=1.
